sram_req_ctrl: RTL and testbench

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_pkg.sv | 10 +
 rtl/sram_resp_fifo.sv | 53 +++++
 rtl/sram_req_ctrl.sv | 119 +++++++++++
 tb/tb_sram_req_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and FSM state type for the SRAM request controller.
package sram_pkg;
  localparam int SRAM_ADDR_W = 6;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// Synchronous read-response queue. The caller never pushes when full and
// never pops when empty; the pop guard below is only a safety net.
module sram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front end for a single-port SRAM macro with a one-cycle read.
// Define SRAM_REQ_CTRL_INIT_EN to zero-fill the whole macro while in INIT.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | after reset; requests blocked (optional zero-fill sweep)
// ST_RUN  | accepting requests; reads throttled by response-queue room
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic             r_inflight;
  logic             w_accept;
  logic             w_pop;
  logic             w_read_room;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_occ;

  // Reads already committed: queued + the one whose data is on sram_o now.
  assign w_pop       = resp_valid && resp_ready;
  assign w_occ       = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
  assign w_read_room = (w_occ < (CNT_W + 1)'(RESP_DEPTH));
  assign w_accept    = req_valid && req_ready;
  assign sram_oeb    = ~r_inflight;
  assign resp_valid  = !w_fifo_empty;

`ifdef SRAM_REQ_CTRL_INIT_EN
  logic [ADDR_W-1:0] r_init_addr;
  logic              w_init_last;

  assign w_init_last = (r_init_addr == '1);

  always_ff @(posedge clk) begin
    if (rst) r_init_addr <= '0;
    else if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_accept && !req_we;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    sram_csb    = 1'b1;
    sram_web    = 1'b1;
    sram_a      = req_addr;
    sram_i      = req_wdata;
    case (r_state)
      ST_INIT: begin
`ifdef SRAM_REQ_CTRL_INIT_EN
        if (!rst) begin
          sram_csb = 1'b0;
          sram_web = 1'b0;
          sram_a   = r_init_addr;
          sram_i   = '0;
        end
        if (w_init_last) w_state_nxt = ST_RUN;
`else
        w_state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        req_ready = !rst && (req_we || w_read_room);
        if (req_valid && req_ready) begin
          sram_csb = 1'b0;
          sram_web = ~req_we;
        end
      end
    endcase
  end

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (DATA_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_wdata (sram_o),
    .i_pop   (w_pop),
    .o_rdata (resp_rdata),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM macro plus a queue-based reference
// model of accepted reads; honours SRAM_REQ_CTRL_INIT_EN like the design.
module tb_sram_req_ctrl;
  localparam int AW     = 6;
  localparam int DW     = 32;
  localparam int DEPTH  = 2;
  localparam int NWORDS = 1 << AW;
`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam int INIT_LEN = NWORDS;
  localparam bit INIT_WR  = 1'b1;
`else
  localparam int INIT_LEN = 1;
  localparam bit INIT_WR  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i, sram_o;

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
  );

  // Behavioural macro: write or read latched at the clock edge, data visible next cycle.
  logic [DW-1:0] mac_mem [NWORDS];
  logic [DW-1:0] mac_dout;
  logic          preload;

  function automatic logic [DW-1:0] seed_word(input int a);
    return DW'(32'h5A00_0000 ^ (a * 32'h0101_0107));
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < NWORDS; k++) mac_mem[k] <= seed_word(k);
    end else if (!sram_csb) begin
      if (!sram_web) mac_mem[sram_a] <= sram_i;
      else           mac_dout        <= mac_mem[sram_a];
    end
  end
  assign sram_o = sram_oeb ? 32'h0BAD_0BAD : mac_dout;

  // Reference model: memory image plus queue of accepted reads and their due cycle.
  logic [DW-1:0] ref_mem [NWORDS];
  logic [DW-1:0] q_data[$];
  int            q_due[$];
  int            cyc = 0;
  int            init_left = 0;
  bit            prev_rd = 1'b0;
  int            n_checks = 0;
  int            n_err = 0;
  bit            last_valid, last_ready;
  logic [DW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic step();
    bit e_ready, e_valid, e_acc, e_pop;
    e_ready = 1'b0; e_valid = 1'b0; e_acc = 1'b0; e_pop = 1'b0;
    @(negedge clk);
    if (rst) begin
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_csb", sram_csb, 1'b1);
    end else begin
      e_valid = (q_data.size() > 0) && (q_due[0] <= cyc);
      e_pop   = e_valid && resp_ready;
      if (init_left > 0) e_ready = 1'b0;
      else e_ready = req_we || ((q_data.size() - int'(e_pop)) < DEPTH);
      e_acc = req_valid && e_ready;
      chk("req_ready", req_ready, e_ready);
      chk("resp_valid", resp_valid, e_valid);
      if (e_valid) chk("resp_rdata", resp_rdata, q_data[0]);
      chk("sram_oeb", sram_oeb, !prev_rd);
      if (init_left > 0) chk("init_csb", sram_csb, !INIT_WR);
      else chk("sram_csb", sram_csb, !e_acc);
      if (e_acc) begin
        chk("sram_web", sram_web, !req_we);
        chk("sram_a", sram_a, req_addr);
        if (req_we) chk("sram_i", sram_i, req_wdata);
      end
    end
    last_valid = resp_valid;
    last_ready = req_ready;
    last_rdata = resp_rdata;
    @(posedge clk);
    if (rst) begin
      q_data.delete();
      q_due.delete();
      prev_rd   = 1'b0;
      init_left = INIT_LEN;
    end else begin
      if (e_pop) begin
        void'(q_data.pop_front());
        void'(q_due.pop_front());
      end
      if (e_acc && req_we) ref_mem[req_addr] = req_wdata;
      else if (e_acc) begin
        q_data.push_back(ref_mem[req_addr]);
        q_due.push_back(cyc + 2);
      end
      prev_rd = e_acc && !req_we;
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0 && INIT_WR)
          for (int k = 0; k < NWORDS; k++) ref_mem[k] = '0;
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    int cnt, nlow, acc, nret;
    rst = 1'b1; preload = 1'b1; resp_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < NWORDS; k++) ref_mem[k] = seed_word(k);
    step();
    preload = 1'b0;
    step();
    rst = 1'b0;
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_oeb", sram_oeb, 1'b1);
    chk("reset_ready", req_ready, 1'b0);

    cnt = 0;
    for (int k = 0; k < INIT_LEN; k++) begin
      step();
      if (!last_ready) cnt++;
    end
    chk("init_ready_low_cycles", cnt, INIT_LEN);
    chk("run_ready", req_ready, 1'b1);

`ifdef SRAM_REQ_CTRL_INIT_EN
    drive(1'b1, 1'b0, AW'(63), '0); step();
    drive(1'b0, 1'b0, '0, '0); step(); step();
    chk("init_63_valid", last_valid, 1'b1);
    chk("init_63_zero", last_rdata, 32'h0);
`endif

    // write then read, 2-cycle latency
    drive(1'b1, 1'b1, AW'(5), 32'hDEADBEEF); step();
    drive(1'b1, 1'b0, AW'(5), '0); step();
    chk("rd5_ready", last_ready, 1'b1);
    drive(1'b0, 1'b0, '0, '0); step();
    chk("rd5_lat1_valid", last_valid, 1'b0);
    step();
    chk("rd5_lat2_valid", last_valid, 1'b1);
    chk("rd5_data", last_rdata, 32'hDEADBEEF);

    // read the cycle after a write to the same address
    drive(1'b1, 1'b1, AW'(9), 32'h1); step();
    drive(1'b1, 1'b0, AW'(9), '0); step();
    drive(1'b0, 1'b0, '0, '0); step(); step();
    chk("raw9_data", last_rdata, 32'h1);
    chk("raw9_valid", last_valid, 1'b1);

    // back-to-back reads 0..7
    cnt = 0; nlow = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, AW'(k), '0); step();
      if (!last_ready) nlow++;
      if (k >= 2 && last_valid) cnt++;
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      step();
      if (last_valid) cnt++;
    end
    chk("b2b_ready_drops", nlow, 0);
    chk("b2b_resp_count", cnt, 8);
    step();
    chk("b2b_done", last_valid, 1'b0);

    // backpressure: only DEPTH reads accepted while resp_ready low
    resp_ready = 1'b0; acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, AW'(20 + acc), '0); step();
      if (last_ready) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_ready_low", last_ready, 1'b0);
    drive(1'b1, 1'b1, AW'(30), 32'h0000_0123); step();
    chk("bp_write_ready", last_ready, 1'b1);
    resp_ready = 1'b1; nret = 0;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      drive(1'b1, 1'b0, AW'(20 + acc), '0); step();
      if (last_ready) acc++;
      if (last_valid) nret++;
    end
    drive(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      if (last_valid) nret++;
    end
    chk("bp_all_accepted", acc, 4);
    chk("bp_returned", nret, 4);

    // reset with two queued responses
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, AW'(40), '0); step();
    drive(1'b1, 1'b0, AW'(41), '0); step();
    drive(1'b0, 1'b0, '0, '0); step(); step();
    chk("pre_rst_valid", last_valid, 1'b1);
    rst = 1'b1; step();
    chk("rst_flush_valid", resp_valid, 1'b0);
    rst = 1'b0; resp_ready = 1'b1; cnt = 0;
    for (int k = 0; k < INIT_LEN + 5; k++) begin
      step();
      if (last_valid) cnt++;
    end
    chk("no_stale_resp", cnt, 0);

    // randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 15)), $urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drive(1'b0, 1'b0, '0, '0);
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("drained", resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
